// File: rtl/ctc_pkg.sv
// Shared types and helpers for the IR carrier generator.
// CARRIER_DUTY25_EN selects the ~25% duty phase split in phase_len().
package ctc_pkg;

   typedef enum logic [1:0] {S_IDLE, S_FORCED, S_HIGH, S_LOW} e_ctc_state;

   localparam int CTC_BITS_DEFAULT = 8;

   // Length in prescaled ticks of the high or low phase for value v.
   function automatic logic [31:0] phase_len(input logic [31:0] v, input logic high);
      logic [31:0] full;
      logic [31:0] high_len;
      full = v + 32'd1;
`ifdef CARRIER_DUTY25_EN
      high_len = ((full >> 1) == 32'd0) ? 32'd1 : (full >> 1);
      return high ? high_len : ((full << 1) - high_len);
`else
      high_len = full;
      return high ? high_len : full;
`endif
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into a one-cycle carrier tick every DIV clocks.
// clear_in restarts the division so a fresh burst starts on a full tick.
module tick_prescaler #(
   parameter int DIV = 1
) (
   input  logic clock_in,
   input  logic reset_n_in,
   input  logic clear_in,
   output logic tick_out
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] count;

   assign tick_out = (count == CW'(DIV - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         count <= '0;
      end else if (clear_in || tick_out) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/carrier_generator.sv
// IR carrier generator: square-wave bursts or forced-high output for the IR LED.
// Define CARRIER_DUTY25_EN for ~25% duty at unchanged period; 50% duty otherwise.
module carrier_generator
   import ctc_pkg::*;
#(
   parameter int CTC_BITS     = CTC_BITS_DEFAULT,
   parameter int PRESCALE_DIV = 1
) (
   input  logic                clock_in,
   input  logic                reset_n_in,
   input  logic                enable_in,
   input  logic                forced_in,
   input  logic                wr_strobe_in,
   input  logic [CTC_BITS-1:0] value_in,
   output logic                carrier_out,
   output logic                active_out
);

   localparam int CNT_W = CTC_BITS + 1;

   e_ctc_state          state;
   logic [CTC_BITS-1:0] shadow;
   logic [CTC_BITS-1:0] shadow_next;
   logic [CTC_BITS-1:0] active_val;
   logic [CNT_W-1:0]    counter;
   logic [CNT_W-1:0]    phase_last;
   logic                start_burst;
   logic                tick;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      shadow_next = wr_strobe_in ? value_in : shadow;
      start_burst = ((state == S_IDLE) || (state == S_FORCED)) && !forced_in && enable_in;
      phase_last  = CNT_W'(phase_len(32'(active_val), state == S_HIGH) - 32'd1);
   end

   // NOTE: the shadow is a plain data register, so it takes the async reset like any other flop.
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         shadow <= '0;
      end else if (wr_strobe_in) begin
         shadow <= value_in;
      end
   end

   tick_prescaler #(.DIV(PRESCALE_DIV)) u_prescaler (
      .clock_in   (clock_in),
      .reset_n_in (reset_n_in),
      .clear_in   (start_burst),
      .tick_out   (tick)
   );

   // Priority forced > enable > idle; counter holds elapsed ticks of the current phase,
   // whose length is frozen in active_val so mid-phase writes wait for the boundary.
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state       <= S_IDLE;
         carrier_out <= 1'b0;
         active_out  <= 1'b0;
         active_val  <= '0;
         counter     <= '0;
      end else if (forced_in) begin
         state       <= S_FORCED;
         carrier_out <= 1'b1;
         active_out  <= 1'b1;
         counter     <= '0;
      end else if (start_burst) begin
         state       <= S_HIGH;
         carrier_out <= 1'b1;
         active_out  <= 1'b1;
         active_val  <= shadow_next;
         counter     <= '0;
      end else if (!enable_in) begin
         state       <= S_IDLE;
         carrier_out <= 1'b0;
         active_out  <= 1'b0;
         counter     <= '0;
      end else if (tick) begin
         if (counter == phase_last) begin
            state       <= (state == S_HIGH) ? S_LOW : S_HIGH;
            carrier_out <= (state == S_LOW);
            active_val  <= shadow_next;
            counter     <= '0;
         end else begin
            counter <= counter + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_carrier_generator.sv
// Self-checking bench for carrier_generator: two instances (prescale 1 and 3) against a
// clock-counting behavioural model, plus directed phase-length checks.
module tb_carrier_generator;

   localparam int CTC_BITS = 8;

   logic                clock_in = 1'b0;
   logic                reset_n_in;
   logic                enable_in;
   logic                forced_in;
   logic                wr_strobe_in;
   logic [CTC_BITS-1:0] value_in;
   logic                carrier1, active1, carrier3, active3;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clock_in = ~clock_in;

   carrier_generator #(.CTC_BITS(CTC_BITS), .PRESCALE_DIV(1)) dut1 (
      .clock_in     (clock_in),
      .reset_n_in   (reset_n_in),
      .enable_in    (enable_in),
      .forced_in    (forced_in),
      .wr_strobe_in (wr_strobe_in),
      .value_in     (value_in),
      .carrier_out  (carrier1),
      .active_out   (active1)
   );

   carrier_generator #(.CTC_BITS(CTC_BITS), .PRESCALE_DIV(3)) dut3 (
      .clock_in     (clock_in),
      .reset_n_in   (reset_n_in),
      .enable_in    (enable_in),
      .forced_in    (forced_in),
      .wr_strobe_in (wr_strobe_in),
      .value_in     (value_in),
      .carrier_out  (carrier3),
      .active_out   (active3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Model: mode 0 off, 1 forced, 2 bursting; left = clocks remaining in the current phase.
   typedef struct {
      int mode;
      bit high;
      int left;
      int shadow;
   } mdl_t;

   mdl_t m1, m3;

   function automatic int len_ticks(input int v, input bit high);
`ifdef CARRIER_DUTY25_EN
      int h = (v + 1) / 2;
      if (h < 1) h = 1;
      return high ? h : 2 * (v + 1) - h;
`else
      return v + 1;
`endif
   endfunction

   function automatic mdl_t step(input mdl_t m, input bit en, input bit fo, input bit st,
                                 input int val, input int p);
      mdl_t n = m;
      int sh = st ? val : m.shadow;
      if (fo) begin
         n.mode = 1;
      end else if (en) begin
         if (m.mode != 2) begin
            n.mode = 2;
            n.high = 1'b1;
            n.left = len_ticks(sh, 1'b1) * p;
         end else begin
            n.left = m.left - 1;
            if (n.left == 0) begin
               n.high = !m.high;
               n.left = len_ticks(sh, n.high) * p;
            end
         end
      end else begin
         n.mode = 0;
      end
      n.shadow = sh;
      return n;
   endfunction

   function automatic mdl_t mdl_reset();
      mdl_t n;
      n.mode = 0; n.high = 1'b0; n.left = 0; n.shadow = 0;
      return n;
   endfunction

   function automatic logic exp_car(input mdl_t m);
      return (m.mode == 1) || (m.mode == 2 && m.high);
   endfunction

   function automatic logic exp_act(input mdl_t m);
      return m.mode != 0;
   endfunction

   always @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         m1 = mdl_reset();
         m3 = mdl_reset();
      end else begin
         m1 = step(m1, enable_in, forced_in, wr_strobe_in, int'(value_in), 1);
         m3 = step(m3, enable_in, forced_in, wr_strobe_in, int'(value_in), 3);
      end
   end

   always @(negedge clock_in) begin
      if (chk_en) begin
         check("model_carrier_p1", carrier1, exp_car(m1));
         check("model_active_p1",  active1,  exp_act(m1));
         check("model_carrier_p3", carrier3, exp_car(m3));
         check("model_active_p3",  active3,  exp_act(m3));
      end
   end

   task automatic tick();
      @(posedge clock_in);
      #1;
   endtask

   task automatic write_value(input int v);
      value_in     = CTC_BITS'(v);
      wr_strobe_in = 1'b1;
      tick();
      wr_strobe_in = 1'b0;
   endtask

   // Counts consecutive samples at level lvl from now; bounded so a stuck output still ends.
   task automatic expect_run(input string name, input bit slow, input logic lvl, input int len);
      int cnt = 0;
      while (((slow ? carrier3 : carrier1) === lvl) && cnt < len + 8) begin
         cnt++;
         tick();
      end
      check(name, cnt, len);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n_in   = 1'b0;
      enable_in    = 1'b0;
      forced_in    = 1'b0;
      wr_strobe_in = 1'b0;
      value_in     = '0;
      repeat (3) tick();
      check("reset_carrier_p1", carrier1, 1'b0);
      check("reset_active_p1",  active1,  1'b0);
      check("reset_carrier_p3", carrier3, 1'b0);
      check("reset_active_p3",  active3,  1'b0);
      reset_n_in = 1'b1;
      chk_en     = 1'b1;
      tick();

`ifndef CARRIER_DUTY25_EN
      // T1: v=3, 4 high / 4 low, high on the first clock after enable
      write_value(3);
      enable_in = 1'b1;
      tick();
      check("t1_first_high", carrier1, 1'b1);
      expect_run("t1_high_a", 1'b0, 1'b1, 4);
      expect_run("t1_low_a",  1'b0, 1'b0, 4);
      expect_run("t1_high_b", 1'b0, 1'b1, 4);
      expect_run("t1_low_b",  1'b0, 1'b0, 4);
      // T3: write 7 two samples into a high phase
      tick();
      write_value(7);
      expect_run("t3_high_rest", 1'b0, 1'b1, 2);
      expect_run("t3_low_8",     1'b0, 1'b0, 8);
      // T4: v=5 takes effect at the next boundary, then enable drops mid-high
      write_value(5);
      expect_run("t4_high_rest", 1'b0, 1'b1, 7);
      expect_run("t4_low_6",     1'b0, 1'b0, 6);
      tick();
      tick();
      enable_in = 1'b0;
      tick();
      check("t4_drop_carrier", carrier1, 1'b0);
      check("t4_drop_active",  active1,  1'b0);
      tick();
      enable_in = 1'b1;
      tick();
      check("t4_restart_high", carrier1, 1'b1);
      expect_run("t4_full_high", 1'b0, 1'b1, 6);
      expect_run("t4_low_after", 1'b0, 1'b0, 6);
      enable_in = 1'b0;
      tick();
`else
      // T6: duty 25%, v=7 -> 4/12, v=0 -> 1/1
      write_value(7);
      enable_in = 1'b1;
      tick();
      expect_run("t6_high_4",  1'b0, 1'b1, 4);
      expect_run("t6_low_12",  1'b0, 1'b0, 12);
      expect_run("t6_high_4b", 1'b0, 1'b1, 4);
      enable_in = 1'b0;
      tick();
      write_value(0);
      enable_in = 1'b1;
      tick();
      expect_run("t6_high_1",  1'b0, 1'b1, 1);
      expect_run("t6_low_1",   1'b0, 1'b0, 1);
      expect_run("t6_high_1b", 1'b0, 1'b1, 1);
      enable_in = 1'b0;
      tick();
`endif

      // T2: forced high
      forced_in = 1'b1;
      tick();
      check("t2_forced_carrier", carrier1, 1'b1);
      check("t2_forced_active",  active1,  1'b1);
      repeat (20) tick();
      check("t2_forced_hold", carrier3, 1'b1);
      forced_in = 1'b0;
      tick();
      check("t2_release_carrier", carrier1, 1'b0);
      check("t2_release_active",  active1,  1'b0);

      // T5: prescale 3, v=0 -> 3 high / 3 low, async reset mid-high
      write_value(0);
      enable_in = 1'b1;
      tick();
      expect_run("t5_high_3", 1'b1, 1'b1, 3);
      expect_run("t5_low_3",  1'b1, 1'b0, 3);
      tick();
      #1 reset_n_in = 1'b0;
      #1;
      check("t5_async_carrier", carrier3, 1'b0);
      check("t5_async_active",  active3,  1'b0);
      enable_in = 1'b0;
      tick();
      tick();
      reset_n_in = 1'b1;
      tick();
      tick();
      check("t5_no_resume", carrier3, 1'b0);
      enable_in = 1'b1;
      tick();
      check("t5_resume", carrier3, 1'b1);
      enable_in = 1'b0;
      tick();

      // Randomized traffic checked every cycle by the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 63) == 0) enable_in = ~enable_in;
         if (forced_in) forced_in = ($urandom_range(0, 7) != 0);
         else           forced_in = ($urandom_range(0, 199) == 0);
         if (wr_strobe_in) wr_strobe_in = ($urandom_range(0, 2) == 0);
         else              wr_strobe_in = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 49) == 0) value_in = CTC_BITS'($urandom_range(0, 255));
         else                            value_in = CTC_BITS'($urandom_range(0, 9));
         tick();
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
